cache_refill_ctrl: RTL

Miss handler that sits between the 4-way cache and word-wide backing memory.
- On a cache miss it optionally writes back the dirty victim line as LINE_WORDS single-word memory writes.
- It then fetches the missing line as LINE_WORDS single-word memory reads and assembles them into one cache line.
- It presents the line to the cache with a one-cycle write-enable pulse.
- It produces the cache's new_cacheline/wen inputs and is the memory-facing end of the cache fill path.

---
 rtl/cache_refill_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: on a miss, optionally writes back the dirty victim
// line word by word, then reads the missing line word by word, assembles it,
// and hands it to the cache with a one-cycle fill write-enable.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   miss_i, miss_addr_i              miss request and address (taken when idle)
//   victim_dirty_i/addr_i/line_i     victim line to write back if dirty
//   busy_o                           stall the cache while not idle
//   fill_wen_o/addr_o/line_o         filled line presented to the cache
//   mem_req_o/we_o/addr_o/wdata_o    registered memory beat request
//   mem_ack_i, mem_rdata_i           beat completion and read data
module cache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_i,
  input  logic [ADDR_W-1:0]            miss_addr_i,
  input  logic                         victim_dirty_i,
  input  logic [ADDR_W-1:0]            victim_addr_i,
  input  logic [WORD_W*LINE_WORDS-1:0] victim_line_i,
  output logic                         busy_o,
  output logic                         fill_wen_o,
  output logic [ADDR_W-1:0]            fill_addr_o,
  output logic [WORD_W*LINE_WORDS-1:0] fill_line_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [WORD_W-1:0]            mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [WORD_W-1:0]            mem_rdata_i
);

  localparam int LINE_W  = WORD_W * LINE_WORDS;
  localparam int CNT_W   = $clog2(LINE_WORDS);
  localparam int BYTE_SH = $clog2(WORD_W / 8);
  localparam int OFF_W   = $clog2(LINE_WORDS * WORD_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   miss_base_q, miss_base_d;
  logic [ADDR_W-1:0]   victim_base_q, victim_base_d;
  logic [LINE_W-1:0]   victim_line_q, victim_line_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic                fill_wen_q, fill_wen_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                beat_done;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  endfunction

  // A beat only completes while a request is actually outstanding.
  assign beat_done = mem_req_q && mem_ack_i;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    victim_line_d = victim_line_q;
    fill_line_d   = fill_line_q;
    fill_addr_d   = fill_addr_q;

    case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          miss_base_d   = line_base(miss_addr_i);
          victim_base_d = line_base(victim_addr_i);
          victim_line_d = victim_line_i;
          cnt_d         = '0;
          state_d       = victim_dirty_i ? S_WB : S_RD;
        end
      end
      S_WB: begin
        if (beat_done) begin
          cnt_d = cnt_q + CNT_W'(1);   // wraps to 0 after the last beat
          if (cnt_q == LAST) state_d = S_RD;
        end
      end
      S_RD: begin
        if (beat_done) begin
          fill_line_d[int'(cnt_q)*WORD_W +: WORD_W] = mem_rdata_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d     = S_FILL;
            fill_addr_d = miss_base_q;  // visible during the FILL cycle
          end
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Memory-side outputs are computed from the next state so they come
    // straight from flops and hold steady until the beat is acknowledged.
    mem_req_d   = (state_d == S_WB) || (state_d == S_RD);
    mem_we_d    = (state_d == S_WB);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == S_WB) begin
      mem_addr_d  = victim_base_d + (ADDR_W'(cnt_d) << BYTE_SH);
      mem_wdata_d = victim_line_d[int'(cnt_d)*WORD_W +: WORD_W];
    end else if (state_d == S_RD) begin
      mem_addr_d  = miss_base_d + (ADDR_W'(cnt_d) << BYTE_SH);
    end
    fill_wen_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      victim_line_q <= '0;
      fill_line_q   <= '0;
      fill_addr_q   <= '0;
      fill_wen_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      victim_line_q <= victim_line_d;
      fill_line_q   <= fill_line_d;
      fill_addr_q   <= fill_addr_d;
      fill_wen_q    <= fill_wen_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign fill_wen_o  = fill_wen_q;
  assign fill_addr_o = fill_addr_q;
  assign fill_line_o = fill_line_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
